// File: rtl/pc_pkg.sv
// Shared types and widths for the program-counter fetch controller.
package pc_pkg;

  localparam int PC_W     = 12;
  localparam int IDX_W    = 5;
  localparam int NULL_IDX = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    BR_WAIT = 2'd2,
    HALT    = 2'd3
  } pc_state_e;

endpackage

// File: rtl/pc_branch_cnt.sv
// Saturating taken-branch counter; clear wins over increment.
module pc_branch_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer with branch-target LUT handshake, stall, halt and restart.
// Optional BRANCH_COUNT_EN adds a saturating count of completed branches.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int D = PC_W,
  parameter int A = IDX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [D-1:0] start_addr,
  input  logic         stall,
  input  logic         branch_en,
  input  logic [A-1:0] branch_idx,
  input  logic         halt_in,
  output logic [A-1:0] lut_addr,
  input  logic [D-1:0] lut_target,
  output logic [D-1:0] prog_ctr,
  output logic         fetch_valid,
  output logic         done,
  output logic         bad_branch,
  output logic         wrap,
  output logic [7:0]   branch_count
);

  pc_state_e    state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic [A-1:0] lut_q, lut_d;
  logic         done_q, done_d;
  logic         bad_q, bad_d;
  logic         wrap_q, wrap_d;

  // start overrides stall; stall freezes everything else.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lut_d   = lut_q;
    done_d  = done_q;
    bad_d   = bad_q;
    wrap_d  = wrap_q;
    if (start) begin
      state_d = RUN;
      pc_d    = start_addr;
      done_d  = 1'b0;
      bad_d   = 1'b0;
      wrap_d  = 1'b0;
    end else if (!stall) begin
      case (state_q)
        RUN: begin
          if (halt_in) begin
            state_d = HALT;
            done_d  = 1'b1;
          end else if (branch_en && (branch_idx != A'(NULL_IDX))) begin
            lut_d   = branch_idx;
            state_d = BR_WAIT;
          end else begin
            if (branch_en) bad_d = 1'b1;
            if (&pc_q) wrap_d = 1'b1;
            pc_d = pc_q + D'(1);
          end
        end
        BR_WAIT: begin
          pc_d    = lut_target;
          state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      lut_q   <= '0;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lut_q   <= lut_d;
      done_q  <= done_d;
      bad_q   <= bad_d;
      wrap_q  <= wrap_d;
    end
  end

  assign prog_ctr    = pc_q;
  assign lut_addr    = lut_q;
  assign done        = done_q;
  assign bad_branch  = bad_q;
  assign wrap        = wrap_q;
  assign fetch_valid = (state_q == RUN) && !stall;

`ifdef BRANCH_COUNT_EN
  logic branch_load;
  assign branch_load = (state_q == BR_WAIT) && !stall && !start;

  pc_branch_cnt #(.W(8)) u_branch_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (start),
    .inc_i   (branch_load),
    .count_o (branch_count)
  );
`else
  assign branch_count = 8'd0;
`endif

endmodule
